// File: rtl/data_path_controller.sv
// Sequencer for the R0/R1/ACC mux/adder datapath: accepts a micro-command,
// holds the op's mux selects for cmd_count cycles, then pulses done.
module data_path_controller #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CNT_WIDTH-1:0] cmd_count,
    output logic                 s0,
    output logic                 s1,
    output logic                 s2,
    output logic                 s3,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] remaining
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // select vectors packed as {s3, s2, s1, s0}
    localparam logic [3:0] SEL_IDLE = 4'b0011;

    logic [1:0] state, nstate;
    logic [3:0] sel;

    function automatic logic [3:0] op_sel(input logic [1:0] op);
        case (op)
            2'd0:    op_sel = 4'b0011; // ADD_R0
            2'd1:    op_sel = 4'b0111; // ADD_R1
            2'd2:    op_sel = 4'b1010; // LD_R0
            default: op_sel = 4'b1001; // LD_R1
        endcase
    endfunction

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (cmd_valid) nstate = (cmd_count != '0) ? EXEC : DONE;
            EXEC:    if (remaining == CNT_WIDTH'(1)) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Status outputs are registered from nstate so they line up with state.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= SEL_IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state     <= nstate;
            busy      <= (nstate != IDLE);
            done      <= (nstate == DONE);
            cmd_ready <= (nstate == IDLE);
            case (state)
                IDLE: if (cmd_valid) begin
                    remaining <= cmd_count;
                    if (cmd_count != '0) sel <= op_sel(cmd_op);
                end
                EXEC: begin
                    remaining <= remaining - CNT_WIDTH'(1);
                    if (remaining == CNT_WIDTH'(1)) sel <= SEL_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign {s3, s2, s1, s0} = sel;

endmodule

// File: tb/tb_data_path_controller.sv
// Directed bench for data_path_controller with a small R0/R1/ACC datapath
// model hanging off the select outputs.
module tb_data_path_controller;

    logic       Clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_count;
    logic       s0, s1, s2, s3;
    logic       busy, done;
    logic [3:0] remaining;

    int errors = 0;
    int checks = 0;

    data_path_controller #(.CNT_WIDTH(4)) dut (
        .Clk(Clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .s0(s0), .s1(s1), .s2(s2), .s3(s3),
        .busy(busy), .done(done), .remaining(remaining)
    );

    always #5 Clk = ~Clk;

    // datapath: R0/R1 muxed from S3, ACC always accumulates S2
    logic       dp_rst;
    logic [7:0] r0, r1, acc, s2o, s3o;
    assign s2o = s2 ? r1 : r0;
    assign s3o = s3 ? acc : s2o;
    always_ff @(posedge Clk) begin
        if (dp_rst) begin
            r0  <= 8'd2;
            r1  <= 8'd2;
            acc <= 8'd2;
        end else begin
            r0  <= s0 ? r0 : s3o;
            r1  <= s1 ? r1 : s3o;
            acc <= acc + s2o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] sel, input logic b,
                           input logic d, input logic r, input logic [3:0] rem);
        chk({tag, ".sel"}, {28'd0, s3, s2, s1, s0}, {28'd0, sel});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
        chk({tag, ".ready"}, {31'd0, cmd_ready}, {31'd0, r});
        chk({tag, ".rem"}, {28'd0, remaining}, {28'd0, rem});
    endtask

    initial begin
        // reset with cmd_valid asserted: nothing may be accepted
        reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_count = 4'd3; dp_rst = 1'b1;
        tick(); tick();
        chk_out("rst", 4'b0011, 1'b0, 1'b0, 1'b1, 4'd0);
        reset = 1'b0; cmd_valid = 1'b0;
        tick();
        chk_out("post_rst", 4'b0011, 1'b0, 1'b0, 1'b1, 4'd0);

        // ADD_R0 count 3, datapath seeded to 2 at the accept edge
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_count = 4'd3;
        tick();
        cmd_valid = 1'b0; dp_rst = 1'b0;
        for (int i = 3; i >= 1; i--) begin
            chk_out($sformatf("add_r0.exec%0d", i), 4'b0011, 1'b1, 1'b0, 1'b0, 4'(i));
            tick();
        end
        chk_out("add_r0.done", 4'b0011, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("add_r0.acc", {24'd0, acc}, 32'd8);
        chk("add_r0.r0", {24'd0, r0}, 32'd2);
        chk("add_r0.r1", {24'd0, r1}, 32'd2);
        tick();
        chk_out("add_r0.idle", 4'b0011, 1'b0, 1'b0, 1'b1, 4'd0);
        chk("add_r0.acc_idle", {24'd0, acc}, 32'd10);

        // LD_R1 count 1: R1 takes ACC (12) at the single execute edge
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_count = 4'd1;
        tick();
        cmd_valid = 1'b0;
        chk_out("ld_r1.exec", 4'b1001, 1'b1, 1'b0, 1'b0, 4'd1);
        chk("ld_r1.acc", {24'd0, acc}, 32'd12);
        chk("ld_r1.r1_hold", {24'd0, r1}, 32'd2);
        tick();
        chk_out("ld_r1.done", 4'b0011, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("ld_r1.r1", {24'd0, r1}, 32'd12);
        chk("ld_r1.r0", {24'd0, r0}, 32'd2);
        tick();
        chk_out("ld_r1.idle", 4'b0011, 1'b0, 1'b0, 1'b1, 4'd0);

        // count 0 with ADD_R1: straight to DONE, s2 stays 0
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_count = 4'd0;
        tick();
        cmd_valid = 1'b0;
        chk_out("cnt0.done", 4'b0011, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        chk_out("cnt0.idle", 4'b0011, 1'b0, 1'b0, 1'b1, 4'd0);

        // cmd_valid held through a 4-cycle ADD_R0 while op/count change
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_count = 4'd4;
        tick();
        cmd_op = 2'd2; cmd_count = 4'd2;
        for (int i = 4; i >= 1; i--) begin
            chk_out($sformatf("held.exec%0d", i), 4'b0011, 1'b1, 1'b0, 1'b0, 4'(i));
            tick();
        end
        chk_out("held.done", 4'b0011, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        chk_out("held.idle", 4'b0011, 1'b0, 1'b0, 1'b1, 4'd0);
        tick();
        cmd_valid = 1'b0;
        chk_out("held.second", 4'b1010, 1'b1, 1'b0, 1'b0, 4'd2);
        tick(); tick();
        chk_out("held.second_done", 4'b0011, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();

        // reset in the 2nd EXEC cycle of an ADD_R1 count 5
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_count = 4'd5;
        tick();
        cmd_valid = 1'b0;
        chk_out("mid.exec1", 4'b0111, 1'b1, 1'b0, 1'b0, 4'd5);
        tick();
        chk_out("mid.exec2", 4'b0111, 1'b1, 1'b0, 1'b0, 4'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_out("mid.rst", 4'b0011, 1'b0, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("mid.no_done%0d", i), {31'd0, done}, 32'd0);
            chk($sformatf("mid.busy%0d", i), {31'd0, busy}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_path_controller.md
Name: data_path_controller

Overview:
- Control sequencer for the 3-register mux/adder datapath (R0, R1, ACC, select muxes S0–S3).
- Accepts micro-commands over a valid/ready handshake and drives the four mux selects for a programmed number of cycles.
- Signals completion with a one-cycle done pulse.
- Sits between a host FSM or testbench and the datapath. Select outputs connect 1:1 to the datapath s0..s3 inputs.

Parameters:
- CNT_WIDTH, 4, width of the repeat count and the remaining-cycle counter.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  operation code (see Behaviour)
- cmd_count  input  CNT_WIDTH  number of execute cycles, 0..2^CNT_WIDTH-1
- s0  output  1  R0 input select: 0 = S3 output, 1 = R0 (hold)
- s1  output  1  R1 input select: 0 = S3 output, 1 = R1 (hold)
- s2  output  1  adder operand select: 0 = R0, 1 = R1
- s3  output  1  S3 select: 0 = S2 output, 1 = ACC
- busy  output  1  command in progress (EXEC or DONE)
- done  output  1  one-cycle completion pulse
- remaining  output  CNT_WIDTH  execute cycles still to run

Behaviour:
- Clock and reset: one clock, Clk. reset is synchronous and active-high. All outputs are registered (Moore); there is no combinational path from cmd_* to s0..s3.
- Reset values:
  - State = IDLE.
  - s0 = 1, s1 = 1, s2 = 0, s3 = 0 (idle selects).
  - busy = 0, done = 0, remaining = 0.
  - cmd_ready = 1 in the cycle after reset deasserts.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready = 1; selects hold idle values.
  - Handshake fires at a rising edge where cmd_valid & cmd_ready. The controller latches op and loads remaining = cmd_count.
  - Next state: EXEC if cmd_count != 0, else DONE.
- EXEC:
  - cmd_ready = 0, busy = 1; selects are driven from the latched op.
  - remaining decrements by 1 at each edge.
  - When remaining == 1 at an edge, the next state is DONE and remaining becomes 0.
- DONE:
  - Exactly one cycle; done = 1, busy = 1, cmd_ready = 0, selects return to idle values.
  - Next state is IDLE.
- Op encoding (selects held for every EXEC cycle):
  - 0 ADD_R0: s0=1, s1=1, s2=0, s3=0. R0/R1 hold; ACC <= ACC + R0.
  - 1 ADD_R1: s0=1, s1=1, s2=1, s3=0. R0/R1 hold; ACC <= ACC + R1.
  - 2 LD_R0: s0=0, s1=1, s2=0, s3=1. R0 <= ACC; R1 holds.
  - 3 LD_R1: s0=1, s1=0, s2=0, s3=1. R1 <= ACC; R0 holds.
- Datapath fact: ACC loads ACC + S2 output on every edge regardless of state. The controller guarantees hold only for R0/R1; ACC keeps accumulating R0 in IDLE, DONE and LD_* cycles.
- Timing for count N >= 1:
  - Accept at edge k.
  - Selects active for cycles k+1..k+N (exactly N datapath update edges, at the ends of those cycles).
  - done high in cycle k+N+1.
  - cmd_ready = 1 again in cycle k+N+2.
- Count 0: accept at edge k, done high in cycle k+1, no EXEC cycle, selects never leave idle values.
- cmd_valid while not IDLE: ignored, not accepted, no side effect. The host must hold cmd_valid until accepted.
- Reset mid-operation (EXEC or DONE): next cycle the state is IDLE with all reset values. The pending done is suppressed and the command is not resumed.
- Back-to-back commands: minimum spacing is N+2 cycles between accept edges. There is no accept in the DONE cycle.
- Arithmetic: remaining is unsigned CNT_WIDTH, never wraps below 0. Datapath width and overflow are the datapath's responsibility.

Test Plan:
- Reset: assert reset 2 cycles with cmd_valid = 1 → no accept; after release s0..s3 = 1,1,0,0, busy = 0, done = 0, remaining = 0, cmd_ready = 1.
- ADD_R0, count 3:
  - Controller outputs: s2 = 0, s0 = s1 = 1 for exactly 3 cycles; remaining reads 3, 2, 1; done in cycle 4 after accept; cmd_ready in cycle 5.
  - With datapath (reset_value = 2): ACC = 2 at the accept edge → ACC = 8 at the end of the third EXEC cycle, R0 = R1 = 2.
- LD_R1, count 1: s1 = 0, s3 = 1 for one cycle → R1 equals the ACC value at that edge; R0 unchanged; done the following cycle.
- Count 0 with op = 1: done in cycle 1 after accept, s2 never 1, busy high for one cycle only.
- cmd_valid held high through a 4-cycle command with a different op on cmd_op: only the first command executes; the second is accepted on the first IDLE edge (accept spacing 6 cycles).
- Reset asserted in the 2nd EXEC cycle of count = 5: outputs return to 1,1,0,0 next cycle, done never pulses, remaining = 0, cmd_ready = 1.
